iob_pwm_core: RTL and testbench
===============================

Name: iob_pwm_core

Overview:
- Single-channel PWM waveform generator. It produces the level that software routes onto pin outputs through the GPIO block's output path.
- Software-visible register writes arrive as a pending set: period, duty and polarity values plus a one-cycle load strobe.
- The core double-buffers these values and applies them only at a period boundary, so the waveform never glitches.
- It also provides a prescaler, an end-of-period pulse and a free-running count for status readback.

Parameters:
- CNT_W, 32, width of the period/duty counter and registers.
- PRESC_W, 16, width of the clock prescaler.

Ports:
- clk  input  1  system clock, all logic on rising edge
- arst_n  input  1  asynchronous active-low reset
- en_i  input  1  run enable, level
- update_i  input  1  one-cycle strobe: capture presc_i/period_i/duty_i/pol_i into pending set
- presc_i  input  PRESC_W  tick every presc_i+1 clk cycles
- period_i  input  CNT_W  counter top; period length = period_i+1 ticks
- duty_i  input  CNT_W  active ticks per period
- pol_i  input  1  0 = active-high, 1 = active-low output
- pwm_o  output  1  registered PWM waveform
- period_end_o  output  1  one-cycle pulse, last tick of each period
- pending_o  output  1  pending set not yet applied
- cnt_o  output  CNT_W  current counter value

Behaviour:
- Reset (arst_n=0, asynchronous): all state zero. Pending and active sets are 0, counter 0, prescaler 0.
- Reset output values: pwm_o=0, period_end_o=0, pending_o=0, cnt_o=0.
- Releasing reset mid-operation restarts from this state. There is no memory of the prior waveform.
- Tick generation:
  - While en_i=1, the prescaler counts 0..presc_a; tick=1 when the prescaler equals presc_a, then it wraps to 0.
  - presc_a=0 gives a tick every cycle.
- Counter:
  - On tick, cnt wraps to 0 if cnt==period_a, otherwise cnt+1.
  - period_a=0 gives cnt fixed at 0 and a boundary on every tick.
- Boundary: boundary = tick && cnt==period_a.
  - period_end_o is registered: it asserts the cycle after the boundary cycle, for one clk.
- Waveform:
  - pwm_o(next) = (cnt < duty_a) XOR pol_a, registered, i.e. one clk latency from cnt.
  - duty_a=0 gives a constant inactive level.
  - duty_a > period_a gives a constant active level (compare at full CNT_W width, no truncation).
- Update, while en_i=1:
  - update_i captures the inputs into the pending set and sets pending.
  - At a boundary with pending=1, the active set <= pending set and pending clears.
  - The prescaler and counter restart from 0 on the cycle after a transfer.
  - update_i in the same cycle as a boundary: the boundary transfers the previously pending set (if any); the new capture stays pending for the next boundary.
  - Multiple updates before a boundary: last write wins.
- Disabled (en_i=0):
  - Prescaler and counter held at 0.
  - pwm_o(next) = pol_a (inactive level); period_end_o=0.
  - A pending set transfers to active on the next clk, so pending_o clears one cycle after update_i.
- Enable rising: the first tick cycle sees cnt=0. The waveform starts with the active phase, delayed by one clk on pwm_o.
- Enable falling mid-period: counter cleared immediately. No partial-period completion.
- Arithmetic: counters unsigned, wrap only by comparison, never by overflow.
  - period_i = 2^CNT_W-1 is legal: the counter wraps from all-ones to 0 via the compare.

Decomposition:
- Shared package/header iob_pwm_pkg holds:
  - default CNT_W and PRESC_W
  - the config bundle layout {presc, period, duty, pol}, with width constant CFG_W = PRESC_W + 2*CNT_W + 1
- One sub-module is natural: iob_pwm_presc, the prescaler producing tick from en_i, presc_a and a restart input.
- Shadow registers, counter and compare stay in the top.
- Pending/active registers use the codebase's standard enable register primitive with arst_n.

Test Plan:
- Reset check: assert arst_n=0 mid-run -> pwm_o, period_end_o, pending_o and cnt_o are 0 in the same cycle, asynchronously.
- Basic waveform: presc=0, period=9, duty=3, pol=0, update, en=1.
  - pwm_o high 3 / low 7 clks, repeating.
  - period_end_o pulses every 10 clks.
  - First high on the clk after en.
- Prescaler and polarity: presc=1, period=3, duty=1, pol=1 -> pwm_o low 2 clks, high 6 clks; period_end_o every 8 clks.
- Glitch-free update: running with period=9/duty=3, pulse update with duty=7 mid-period.
  - pending_o=1 until the boundary.
  - The current period stays 3 high; the next period is 7 high.
- Boundary collision: update_i (duty=5) asserted on the exact boundary cycle with no prior pending -> applied at the following boundary, not the current one.
- Extremes:
  - duty=0 -> pwm_o constant 0.
  - duty=12 with period=9 -> constant 1.
  - period=0, duty=1 -> constant 1, with period_end_o high every cycle.
  - en=0 with update -> pending_o clears next clk and pwm_o=pol.

Source files
------------

// File: rtl/iob_pwm_pkg.sv
// Shared widths and configuration bundle layout for the PWM core.
// The bundle is packed MSB-first as {presc, period, duty, pol}.
package iob_pwm_pkg;
   localparam int PWM_CNT_W   = 32;
   localparam int PWM_PRESC_W = 16;
   localparam int CFG_W       = PWM_PRESC_W + 2 * PWM_CNT_W + 1;

   typedef struct packed {
      logic [PWM_PRESC_W-1:0] presc;
      logic [PWM_CNT_W-1:0]   period;
      logic [PWM_CNT_W-1:0]   duty;
      logic                   pol;
   } pwm_cfg_t;
endpackage

// File: rtl/iob_pwm_presc.sv
// Clock prescaler: tick every presc_a+1 cycles while enabled.
// restart forces the count back to 0 so a new period starts aligned.
module iob_pwm_presc #(
   parameter int PRESC_W = iob_pwm_pkg::PWM_PRESC_W
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               en,
   input  logic               restart,
   input  logic [PRESC_W-1:0] presc_a,
   output logic               tick
);
   logic [PRESC_W-1:0] cnt;

   assign tick = en && (cnt == presc_a);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) cnt <= '0;
      else if (!en || restart || tick) cnt <= '0;
      else cnt <= cnt + PRESC_W'(1);
   end
endmodule

// File: rtl/iob_reg_e.sv
// Register with load enable and asynchronous active-low clear.
module iob_reg_e #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         arst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) q <= '0;
      else if (en) q <= d;
   end
endmodule

// File: rtl/iob_pwm_core.sv
// Single-channel PWM with double-buffered config applied at period boundaries.
// Pending set captured on update_i, moved to the active set at a boundary.
module iob_pwm_core
   import iob_pwm_pkg::*;
#(
   parameter int CNT_W   = PWM_CNT_W,
   parameter int PRESC_W = PWM_PRESC_W
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               en_i,
   input  logic               update_i,
   input  logic [PRESC_W-1:0] presc_i,
   input  logic [CNT_W-1:0]   period_i,
   input  logic [CNT_W-1:0]   duty_i,
   input  logic               pol_i,
   output logic               pwm_o,
   output logic               period_end_o,
   output logic               pending_o,
   output logic [CNT_W-1:0]   cnt_o
);
   localparam int CW = PRESC_W + 2 * CNT_W + 1;

   logic [CW-1:0]      cfg_in, cfg_p, cfg_a;
   logic [PRESC_W-1:0] presc_a;
   logic [CNT_W-1:0]   period_a, duty_a, cnt;
   logic               pol_a, pend, tick, boundary, xfer;

   assign cfg_in   = {presc_i, period_i, duty_i, pol_i};
   assign presc_a  = cfg_a[CW-1 -: PRESC_W];
   assign period_a = cfg_a[2*CNT_W -: CNT_W];
   assign duty_a   = cfg_a[CNT_W -: CNT_W];
   assign pol_a    = cfg_a[0];

   assign boundary = tick && (cnt == period_a);
   // When disabled there is no waveform to protect, so apply immediately.
   assign xfer     = pend && (boundary || !en_i);

   iob_reg_e #(.W(CW)) u_cfg_pend (
      .clk(clk), .arst_n(arst_n), .en(update_i), .d(cfg_in), .q(cfg_p)
   );

   iob_reg_e #(.W(CW)) u_cfg_act (
      .clk(clk), .arst_n(arst_n), .en(xfer), .d(cfg_p), .q(cfg_a)
   );

   // A capture in the same cycle as a transfer keeps the flag set.
   iob_reg_e #(.W(1)) u_pend_flag (
      .clk(clk), .arst_n(arst_n), .en(update_i | xfer), .d(update_i), .q(pend)
   );

   iob_pwm_presc #(.PRESC_W(PRESC_W)) u_presc (
      .clk(clk), .arst_n(arst_n), .en(en_i), .restart(xfer),
      .presc_a(presc_a), .tick(tick)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) cnt <= '0;
      else if (!en_i || xfer) cnt <= '0;
      else if (tick) cnt <= (cnt == period_a) ? '0 : cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         pwm_o        <= 1'b0;
         period_end_o <= 1'b0;
      end else begin
         pwm_o        <= en_i ? ((cnt < duty_a) ^ pol_a) : pol_a;
         period_end_o <= en_i && boundary;
      end
   end

   assign pending_o = pend;
   assign cnt_o     = cnt;
endmodule

// File: tb/tb_iob_pwm_core.sv
// Directed bench for iob_pwm_core: vector table of configs plus update corner cases.
module tb_iob_pwm_core;
   logic        clk = 1'b0;
   logic        arst_n;
   logic        en_i, update_i, pol_i;
   logic [15:0] presc_i;
   logic [31:0] period_i, duty_i;
   logic        pwm_o, period_end_o, pending_o;
   logic [31:0] cnt_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] presc;
      logic [31:0] period;
      logic [31:0] duty;
      logic        pol;
      int          hi;   // active clks per period
      int          len;  // period length in clks
   } vec_t;

   vec_t vecs[6];

   iob_pwm_core dut (
      .clk(clk), .arst_n(arst_n), .en_i(en_i), .update_i(update_i),
      .presc_i(presc_i), .period_i(period_i), .duty_i(duty_i), .pol_i(pol_i),
      .pwm_o(pwm_o), .period_end_o(period_end_o), .pending_o(pending_o),
      .cnt_o(cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_check(input string tag);
      arst_n = 1'b0;
      #2;
      chk({tag, " rst pwm"}, 32'(pwm_o), 32'd0);
      chk({tag, " rst pend_end"}, 32'(period_end_o), 32'd0);
      chk({tag, " rst pending"}, 32'(pending_o), 32'd0);
      chk({tag, " rst cnt"}, cnt_o, 32'd0);
      en_i = 1'b0;
      update_i = 1'b0;
      step();
      arst_n = 1'b1;
   endtask

   task automatic load_cfg(input logic [15:0] ps, input logic [31:0] pr,
                           input logic [31:0] du, input logic pl);
      en_i = 1'b0;
      presc_i = ps; period_i = pr; duty_i = du; pol_i = pl;
      update_i = 1'b1;
      step();
      update_i = 1'b0;
      step();
   endtask

   initial begin
      int ph, ediv;
      logic act;
      arst_n = 1'b0; en_i = 1'b0; update_i = 1'b0; pol_i = 1'b0;
      presc_i = '0; period_i = '0; duty_i = '0;

      vecs[0] = '{16'd0, 32'd9, 32'd3,  1'b0, 3,  10};
      vecs[1] = '{16'd1, 32'd3, 32'd1,  1'b1, 2,  8};
      vecs[2] = '{16'd0, 32'd9, 32'd0,  1'b0, 0,  10};
      vecs[3] = '{16'd0, 32'd9, 32'd12, 1'b0, 10, 10};
      vecs[4] = '{16'd0, 32'd0, 32'd1,  1'b0, 1,  1};
      vecs[5] = '{16'd2, 32'd4, 32'd2,  1'b0, 6,  15};

      #12;
      chk("init pwm", 32'(pwm_o), 32'd0);
      chk("init cnt", cnt_o, 32'd0);
      chk("init pending", 32'(pending_o), 32'd0);
      @(posedge clk); #1;
      arst_n = 1'b1;

      // Table-driven steady-state waveforms, each ended by a mid-run async reset.
      for (int v = 0; v < 6; v++) begin
         load_cfg(vecs[v].presc, vecs[v].period, vecs[v].duty, vecs[v].pol);
         chk($sformatf("v%0d pending after load", v), 32'(pending_o), 32'd0);
         en_i = 1'b1;
         ediv = int'(vecs[v].presc) + 1;
         for (int k = 0; k < 2 * vecs[v].len; k++) begin
            step();
            ph  = k % vecs[v].len;
            act = (ph < vecs[v].hi) ? ~vecs[v].pol : vecs[v].pol;
            chk($sformatf("v%0d pwm k%0d", v, k), 32'(pwm_o), 32'(act));
            chk($sformatf("v%0d pend k%0d", v, k), 32'(period_end_o),
                32'(ph == vecs[v].len - 1));
            chk($sformatf("v%0d cnt k%0d", v, k), cnt_o,
                32'(((k + 1) % vecs[v].len) / ediv));
         end
         reset_check($sformatf("v%0d", v));
      end

      // Glitch-free update: duty 3 -> 7 mid-period, then disable mid-period.
      load_cfg(16'd0, 32'd9, 32'd3, 1'b0);
      en_i = 1'b1;
      for (int k = 0; k < 25; k++) begin
         update_i = (k == 4);
         if (k == 4) duty_i = 32'd7;
         step();
         update_i = 1'b0;
         act = (k < 10) ? (k < 3) : ((k % 10) < 7);
         chk($sformatf("glitch pwm k%0d", k), 32'(pwm_o), 32'(act));
         chk($sformatf("glitch pending k%0d", k), 32'(pending_o),
             32'(k >= 4 && k <= 8));
      end
      en_i = 1'b0;
      step();
      chk("disable cnt", cnt_o, 32'd0);
      chk("disable pwm", 32'(pwm_o), 32'd0);
      chk("disable pend_end", 32'(period_end_o), 32'd0);
      reset_check("glitch");

      // Update on the exact boundary cycle with nothing pending.
      load_cfg(16'd0, 32'd9, 32'd3, 1'b0);
      en_i = 1'b1;
      for (int k = 0; k < 30; k++) begin
         update_i = (k == 9);
         if (k == 9) duty_i = 32'd5;
         step();
         update_i = 1'b0;
         act = (k < 20) ? ((k % 10) < 3) : ((k % 10) < 5);
         chk($sformatf("coll pwm k%0d", k), 32'(pwm_o), 32'(act));
         chk($sformatf("coll pending k%0d", k), 32'(pending_o),
             32'(k >= 9 && k <= 18));
      end
      reset_check("coll");

      // Update while disabled: applied on the next clk, output at inactive level.
      en_i = 1'b0;
      presc_i = 16'd0; period_i = 32'd9; duty_i = 32'd3; pol_i = 1'b1;
      update_i = 1'b1;
      step();
      update_i = 1'b0;
      chk("dis pending set", 32'(pending_o), 32'd1);
      step();
      chk("dis pending clr", 32'(pending_o), 32'd0);
      chk("dis pwm old pol", 32'(pwm_o), 32'd0);
      step();
      chk("dis pwm new pol", 32'(pwm_o), 32'd1);
      chk("dis cnt", cnt_o, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
